// File: rtl/voice_frame_sequencer.sv
// ============================================================================
// Module  : voice_frame_sequencer
// Brief   : Issues every voice to the DDS once per sample tick and mixes the
//           returned phases as gated sawtooth voices into one signed sample.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_frame_sequencer #(
    parameter int NUM_VOICES  = 8,
    parameter int DDS_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_voice,
    input  logic [31:0] cfg_delta,
    input  logic        cfg_gate,
    output logic [31:0] delta_phase,
    output logic [7:0]  voice_index,
    input  logic [31:0] output_phase,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int              CNT_W        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [CNT_W-1:0] LAST_VOICE  = CNT_W'(NUM_VOICES - 1);
    localparam logic [7:0]      NUM_VOICES_B = 8'(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         voice_cnt_q, voice_cnt_d;
    logic [7:0]               last_index_q, last_index_d;
    logic [31:0]              delta_q [NUM_VOICES];
    logic [31:0]              delta_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]    gate_q, gate_d;
    logic [DDS_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [DDS_LATENCY-1:0]   pipe_gate_q, pipe_gate_d;
    logic signed [15:0]       acc_q, acc_d;
    logic                     overrun_q, overrun_d;

    logic                     issuing;
    logic                     pipe_busy;
    logic signed [15:0]       saw;
    logic                     unused_phase_bits;

    // Phase bits below the top 12 do not reach the sawtooth.
    assign unused_phase_bits = ^output_phase[19:0];

    // Top 12 phase bits minus 2048 is just the MSB inverted, then sign-extended.
    assign saw = {{4{~output_phase[31]}}, ~output_phase[31], output_phase[30:20]};

    always_comb begin
        delta_d = delta_q;
        gate_d  = gate_q;
        if (cfg_we && (cfg_voice < NUM_VOICES_B)) begin
            delta_d[cfg_voice[CNT_W-1:0]] = cfg_delta;
            gate_d[cfg_voice[CNT_W-1:0]]  = cfg_gate;
        end
    end

    always_comb begin
        state_d      = state_q;
        voice_cnt_d  = voice_cnt_q;
        last_index_d = last_index_q;
        overrun_d    = 1'b0;
        issuing      = 1'b0;
        voice_index  = last_index_q;
        delta_phase  = '0;
        sample_valid = 1'b0;
        sample_data  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d     = ST_ISSUE;
                    voice_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                issuing      = 1'b1;
                overrun_d    = sample_tick;
                voice_index  = 8'(voice_cnt_q);
                delta_phase  = gate_q[voice_cnt_q] ? delta_q[voice_cnt_q] : '0;
                last_index_d = 8'(voice_cnt_q);
                if (voice_cnt_q == LAST_VOICE) begin
                    state_d = ST_DRAIN;
                end else begin
                    voice_cnt_d = voice_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                overrun_d = sample_tick;
                // The head entry is accumulated on this same edge.
                if (!pipe_busy) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                overrun_d    = sample_tick;
                sample_valid = 1'b1;
                sample_data  = acc_q;
                if (sample_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_gate_d    = '0;
        pipe_vld_d[0]  = issuing;
        pipe_gate_d[0] = issuing & gate_q[voice_cnt_q];
        for (int i = 1; i < DDS_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_gate_d[i] = pipe_gate_q[i-1];
        end
        pipe_busy = 1'b0;
        for (int i = 0; i < DDS_LATENCY - 1; i++) begin
            pipe_busy = pipe_busy | pipe_vld_q[i];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if ((state_q == ST_IDLE) && sample_tick) begin
            acc_d = '0;
        end else if (pipe_vld_q[DDS_LATENCY-1] && pipe_gate_q[DDS_LATENCY-1]) begin
            acc_d = acc_q + saw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            voice_cnt_q  <= '0;
            last_index_q <= '0;
            gate_q       <= '0;
            pipe_vld_q   <= '0;
            pipe_gate_q  <= '0;
            acc_q        <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                delta_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            voice_cnt_q  <= voice_cnt_d;
            last_index_q <= last_index_d;
            gate_q       <= gate_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_gate_q  <= pipe_gate_d;
            acc_q        <= acc_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                delta_q[i] <= delta_d[i];
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_frame_sequencer.sv
// ============================================================================
// Module  : tb_voice_frame_sequencer
// Brief   : Directed bench for voice_frame_sequencer with a 3-clock DDS model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_frame_sequencer;

    localparam int NV  = 4;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_voice = '0;
    logic [31:0] cfg_delta = '0;
    logic        cfg_gate = 1'b0;
    logic [31:0] delta_phase;
    logic [7:0]  voice_index;
    logic [31:0] output_phase;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int ref_lat = 0;
    int leak_cnt = 0;

    logic        dds_clear = 1'b0;
    logic [31:0] dds_ram [16];
    logic [31:0] dly [LAT];

    voice_frame_sequencer #(.NUM_VOICES(NV), .DDS_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_delta(cfg_delta), .cfg_gate(cfg_gate),
        .delta_phase(delta_phase), .voice_index(voice_index), .output_phase(output_phase),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // DDS: phase RAM written back every clock, new phase returned LAT clocks later.
    always @(posedge clk) begin
        if (dds_clear) begin
            for (int i = 0; i < 16; i++) dds_ram[i] <= '0;
        end else begin
            dds_ram[voice_index[3:0]] <= dds_ram[voice_index[3:0]] + delta_phase;
        end
        dly[0] <= dds_ram[voice_index[3:0]] + delta_phase;
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign output_phase = dly[LAT-1];

    always @(negedge clk) begin
        if (reset && (!busy || sample_valid) && (delta_phase !== 32'h0)) leak_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(output logic signed [15:0] data, output int lat, output bit to);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 1;
        while (sample_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        to   = (sample_valid !== 1'b1);
        data = sample_data;
        if (sample_ready) @(negedge clk);
    endtask

    task automatic write_cfg(input logic [7:0] v, input logic [31:0] d, input logic g);
        cfg_we = 1'b1; cfg_voice = v; cfg_delta = d; cfg_gate = g;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic clear_phases();
        dds_clear = 1'b1;
        @(negedge clk);
        dds_clear = 1'b0;
    endtask

    task automatic test_reset();
        logic signed [15:0] d;
        int lat;
        bit to;
        reset = 1'b0;
        clear_phases();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sample_valid, overrun} !== 3'b000)
            begin failures++; $display("FAIL reset_flags: busy/valid/overrun=%b expected 000", {busy, sample_valid, overrun}); end
        checks++;
        if (voice_index !== 8'd0 || delta_phase !== 32'd0)
            begin failures++; $display("FAIL reset_dds_if: voice_index=%0d delta=%h expected 0 0", voice_index, delta_phase); end
        checks++;
        if (sample_data !== 16'd0)
            begin failures++; $display("FAIL reset_data: got %h expected 0000", sample_data); end
        reset = 1'b1;
        @(negedge clk);
        run_frame(d, lat, to);
        checks++;
        if (to) begin failures++; $display("FAIL reset_frame_timeout: no sample_valid within %0d cycles", lat); end
        checks++;
        if (d !== 16'sd0) begin failures++; $display("FAIL empty_table_sample: got %0d expected 0", d); end
        checks++;
        if (lat < 1 + NV + LAT - 1 || lat > 1 + NV + LAT + 1)
            begin failures++; $display("FAIL latency_range: got %0d expected %0d+-1", lat, 1 + NV + LAT); end
        ref_lat = lat;
    endtask

    task automatic test_saw();
        logic signed [15:0] d;
        logic signed [15:0] exp_s [2];
        int lat;
        bit to;
        exp_s[0] = -16'sd1792;
        exp_s[1] = -16'sd1536;
        clear_phases();
        write_cfg(8'd0, 32'h1000_0000, 1'b1);
        for (int f = 0; f < 2; f++) begin
            run_frame(d, lat, to);
            checks++;
            if (to || d !== exp_s[f])
                begin failures++; $display("FAIL saw_frame%0d: got %0d (timeout=%0d) expected %0d", f, d, to, exp_s[f]); end
            checks++;
            if (lat !== ref_lat) begin failures++; $display("FAIL saw_latency%0d: got %0d expected %0d", f, lat, ref_lat); end
        end
        for (int v = 1; v < NV; v++) begin
            checks++;
            if (dds_ram[v] !== 32'h0)
                begin failures++; $display("FAIL gated_phase_frozen v%0d: got %h expected 0", v, dds_ram[v]); end
        end
    endtask

    task automatic test_two_voices();
        logic signed [15:0] d;
        logic signed [15:0] exp_s [3];
        int lat;
        bit to;
        exp_s[0] = 16'sd0;
        exp_s[1] = -16'sd4096;
        exp_s[2] = 16'sd0;
        clear_phases();
        write_cfg(8'd0, 32'h8000_0000, 1'b1);
        write_cfg(8'd1, 32'h8000_0000, 1'b1);
        for (int f = 0; f < 3; f++) begin
            run_frame(d, lat, to);
            checks++;
            if (to || d !== exp_s[f])
                begin failures++; $display("FAIL two_voice_frame%0d: got %0d (timeout=%0d) expected %0d", f, d, to, exp_s[f]); end
        end
    endtask

    task automatic test_hold_ready();
        logic signed [15:0] d;
        logic signed [15:0] exp_d;
        int lat;
        bit to;
        exp_d = -16'sd4096;
        sample_ready = 1'b0;
        run_frame(d, lat, to);
        checks++;
        if (to || d !== exp_d)
            begin failures++; $display("FAIL hold_first: got %0d (timeout=%0d) expected %0d", d, to, exp_d); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) sample_tick = 1'b1;
            if (i == 6) sample_tick = 1'b0;
            @(negedge clk);
            checks++;
            if (sample_valid !== 1'b1 || sample_data !== exp_d)
                begin failures++; $display("FAIL hold_stable cyc%0d: valid=%b data=%0d expected 1 %0d", i, sample_valid, $signed(sample_data), exp_d); end
            if (i == 5) begin
                checks++;
                if (overrun !== 1'b1) begin failures++; $display("FAIL hold_overrun: got %b expected 1", overrun); end
            end
            if (i == 6) begin
                checks++;
                if (overrun !== 1'b0) begin failures++; $display("FAIL hold_overrun_pulse: got %b expected 0", overrun); end
            end
        end
        sample_ready = 1'b1;
        sample_tick  = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        checks++;
        if ({sample_valid, busy, overrun} !== 3'b001)
            begin failures++; $display("FAIL release_same_cycle_tick: valid/busy/overrun=%b expected 001", {sample_valid, busy, overrun}); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL dropped_tick_no_frame: busy=%b expected 0", busy); end
    endtask

    task automatic test_tick_during_issue();
        logic signed [15:0] exp_d;
        int lat;
        exp_d = -16'sd1792;
        clear_phases();
        write_cfg(8'd0, 32'h1000_0000, 1'b1);
        write_cfg(8'd1, 32'h0, 1'b0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 3;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1)
            begin failures++; $display("FAIL issue_overrun: overrun=%b busy=%b expected 1 1", overrun, busy); end
        while (sample_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== exp_d)
            begin failures++; $display("FAIL issue_tick_sample: got %0d valid=%b expected %0d", $signed(sample_data), sample_valid, exp_d); end
        checks++;
        if (lat !== ref_lat) begin failures++; $display("FAIL issue_tick_latency: got %0d expected %0d", lat, ref_lat); end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dds_ram[0] !== 32'h1000_0000)
            begin failures++; $display("FAIL issue_tick_single_frame: busy=%b phase0=%h expected 0 10000000", busy, dds_ram[0]); end
    endtask

    task automatic test_cfg_same_cycle();
        logic signed [15:0] d;
        logic signed [15:0] exp_d;
        int lat;
        int n;
        bit to;
        clear_phases();
        write_cfg(8'd0, 32'h0, 1'b0);
        write_cfg(8'd2, 32'h1000_0000, 1'b1);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n = 1;
        while (!(busy === 1'b1 && voice_index === 8'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (voice_index !== 8'd2 || delta_phase !== 32'h1000_0000)
            begin failures++; $display("FAIL cfg_issue_v2: idx=%0d delta=%h expected 2 10000000", voice_index, delta_phase); end
        cfg_we = 1'b1; cfg_voice = 8'd2; cfg_delta = 32'h4000_0000; cfg_gate = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        n++;
        while (sample_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        exp_d = -16'sd1792;
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== exp_d)
            begin failures++; $display("FAIL cfg_old_delta: got %0d valid=%b expected %0d", $signed(sample_data), sample_valid, exp_d); end
        @(negedge clk);
        run_frame(d, lat, to);
        exp_d = -16'sd768;
        checks++;
        if (to || d !== exp_d) begin failures++; $display("FAIL cfg_new_delta: got %0d expected %0d", d, exp_d); end
        write_cfg(8'd200, 32'h2000_0000, 1'b1);
        run_frame(d, lat, to);
        exp_d = 16'sd256;
        checks++;
        if (to || d !== exp_d) begin failures++; $display("FAIL cfg_out_of_range: got %0d expected %0d", d, exp_d); end
    endtask

    task automatic test_reset_mid_frame();
        logic signed [15:0] d;
        logic signed [15:0] exp_d;
        int lat;
        bit to;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sample_valid, overrun} !== 3'b000 || delta_phase !== 32'h0 || voice_index !== 8'd0)
            begin failures++; $display("FAIL midframe_reset: busy/valid/overrun=%b delta=%h idx=%0d expected 000 0 0", {busy, sample_valid, overrun}, delta_phase, voice_index); end
        reset = 1'b1;
        @(negedge clk);
        run_frame(d, lat, to);
        checks++;
        if (to || d !== 16'sd0) begin failures++; $display("FAIL table_cleared: got %0d expected 0", d); end
        clear_phases();
        write_cfg(8'd3, 32'h3000_0000, 1'b1);
        run_frame(d, lat, to);
        exp_d = -16'sd1280;
        checks++;
        if (to || d !== exp_d) begin failures++; $display("FAIL post_reset_frame: got %0d expected %0d", d, exp_d); end
        checks++;
        if (lat !== ref_lat) begin failures++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, ref_lat); end
    endtask

    task automatic test_idle_delta();
        checks++;
        if (leak_cnt !== 0)
            begin failures++; $display("FAIL delta_outside_issue: %0d cycles with nonzero delta, expected 0", leak_cnt); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_two_voices();
        test_hold_ready();
        test_tick_during_issue();
        test_cfg_same_cycle();
        test_reset_mid_frame();
        test_idle_delta();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
